// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: self-clears after reset, serves one-cycle
// fetches in IDLE, and accepts a program image word-by-word in LOAD.
module instr_mem_loadable #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              fetch_req_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  output logic              fetch_ready_o,
  output logic [DATA_W-1:0] instr_o,
  output logic              instr_valid_o,
  output logic              fetch_fault_o,
  input  logic              load_start_i,
  input  logic [ADDR_W-1:0] load_base_i,
  input  logic              load_valid_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              load_last_i,
  output logic              load_ready_o,
  output logic              busy_o
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_LOAD} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     clr_ptr_q, clr_ptr_d;
  logic [IW-1:0]     ld_ptr_q, ld_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [IW-1:0]     mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] instr_q;
  logic              instr_valid_q, fetch_fault_q;
  logic              fetch_acc, addr_bad;
  logic [IW-1:0]     fetch_idx;
  logic              unused_ok;

  // Only the word-index bits of the load base matter; the rest is ignored.
  assign unused_ok = ^{load_base_i[1:0], load_base_i[ADDR_W-1:IW+2]};

  assign fetch_ready_o = (state_q == S_IDLE) && !load_start_i;
  assign load_ready_o  = (state_q == S_LOAD);
  assign busy_o        = (state_q == S_CLEAR) || (state_q == S_LOAD);
  assign fetch_acc     = fetch_req_i && fetch_ready_o;
  assign fetch_idx     = fetch_addr_i[IW+1:2];
  // Misaligned, or any address bit above the word-index field set.
  assign addr_bad      = (fetch_addr_i[1:0] != 2'b00) ||
                         ((fetch_addr_i >> (IW + 2)) != '0);

  // Next-state and write-port selection: CLEAR sweeps zeros, LOAD writes data.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ld_ptr_d  = ld_ptr_q;
    mem_we    = 1'b0;
    mem_waddr = clr_ptr_q;
    mem_wdata = '0;
    case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        clr_ptr_d = IW'(clr_ptr_q + 1'b1);
        if (clr_ptr_q == IW'(DEPTH - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (load_start_i) begin
          state_d  = S_LOAD;
          ld_ptr_d = load_base_i[IW+1:2];
        end
      end
      S_LOAD: begin
        if (load_valid_i) begin
          mem_we    = 1'b1;
          mem_waddr = ld_ptr_q;
          mem_wdata = load_data_i;
          ld_ptr_d  = IW'(ld_ptr_q + 1'b1);  // wraps silently
          if (load_last_i) state_d = S_IDLE;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
      ld_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ld_ptr_q  <= ld_ptr_d;
    end
  end

  // Storage array; contents are erased by the CLEAR sweep, not by reset.
  always_ff @(posedge clk_i) begin
    if (mem_we && !rst_i) mem_q[mem_waddr] <= mem_wdata;
  end

  // Registered fetch response; faulting fetches return a NOP and skip the read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      instr_valid_q <= fetch_acc;
      fetch_fault_q <= fetch_acc && addr_bad;
      if (fetch_acc) instr_q <= addr_bad ? '0 : mem_q[fetch_idx];
    end
  end

  assign instr_o       = instr_q;
  assign instr_valid_o = instr_valid_q;
  assign fetch_fault_o = fetch_fault_q;
endmodule
